// File: rtl/conv1d_mac_acc_pkg.sv
// Shared build-time defaults for the conv1d MAC accumulate stage and its
// downstream bias/requant stages, plus small helpers used by the datapath.
package conv1d_mac_acc_pkg;

   // Output sample width; products are twice this wide.
   localparam int CONV_WIDTH_DATA = 16;
   // Products accumulated per output sample (legal 1..255).
   localparam int CONV_KERNEL_LEN = 3;
   // Accumulator width; must cover 2*WIDTH_DATA + clog2(KERNEL_LEN).
   localparam int CONV_ACC_WIDTH  = 40;
   // Fractional bits dropped at the output (legal 0..2*WIDTH_DATA-1).
   localparam int CONV_SHIFT      = 8;

   // Tap counter width: KERNEL_LEN <= 255 so indices fit in 8 bits.
   localparam int TAP_W = 8;

   // Smallest accumulator width that can never overflow for a kernel.
   function automatic int min_acc_width(input int width_data, input int kernel_len);
      return 2 * width_data + $clog2(kernel_len);
   endfunction

endpackage

// File: rtl/conv1d_round_sat.sv
// Round-half-up, arithmetic right shift and saturate an accumulator value
// down to a signed WIDTH_DATA sample. Purely combinational so the bias and
// requant stages can drop it into their own pipelines.
module conv1d_round_sat
   import conv1d_mac_acc_pkg::*;
#(
   parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
   parameter int WIDTH_DATA = CONV_WIDTH_DATA,
   parameter int SHIFT      = CONV_SHIFT
) (
   input  logic signed [ACC_WIDTH-1:0]  x,
   output logic        [WIDTH_DATA-1:0] y,
   output logic                         sat
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int EW = ACC_WIDTH + 1;

   // Half an output LSB; zero when nothing is shifted out.
   localparam logic signed [EW-1:0] RND =
      (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   localparam logic signed [EW-1:0] MAXV =
      EW'((longint'(1) << (WIDTH_DATA - 1)) - longint'(1));
   localparam logic signed [EW-1:0] MINV =
      EW'(-(longint'(1) << (WIDTH_DATA - 1)));

   logic signed [EW-1:0] x_rnd;
   logic signed [EW-1:0] r;

   // Round, shift, then clip into the signed output range.
   always_comb begin
      x_rnd = $signed({x[ACC_WIDTH-1], x}) + RND;
      r     = x_rnd >>> SHIFT;
      y     = r[WIDTH_DATA-1:0];
      sat   = 1'b0;
      if (r > MAXV) begin
         y   = MAXV[WIDTH_DATA-1:0];
         sat = 1'b1;
      end else if (r < MINV) begin
         y   = MINV[WIDTH_DATA-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/conv1d_mac_acc.sv
// Final carry-propagate and accumulate stage of the conv1d MAC datapath.
// S1 resolves the compressor's (cout, sum) pair into a signed product, S2
// accumulates KERNEL_LEN products, and OUT holds the rounded, saturated
// result behind a valid/ready register. A single advance signal moves all
// stages together, so backpressure freezes the whole pipe.
module conv1d_mac_acc
   import conv1d_mac_acc_pkg::*;
#(
   parameter int WIDTH_DATA = CONV_WIDTH_DATA,
   parameter int KERNEL_LEN = CONV_KERNEL_LEN,
   parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
   parameter int SHIFT      = CONV_SHIFT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2*WIDTH_DATA-1:0]   in_cout,
   input  logic [2*WIDTH_DATA-1:0]   in_sum,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH_DATA-1:0]     out_data,
   output logic                      out_sat,
   output logic                      busy
);

   localparam int PW = 2 * WIDTH_DATA;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_LEN - 1);

   logic                        advance;
   logic [PW-1:0]               p_in;
   logic [PW-1:0]               s1_p;
   logic                        s1_v;
   logic                        s1_last;
   logic [TAP_W-1:0]            tap_cnt;
   logic [TAP_W-1:0]            tap_after;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] p_ext;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic [WIDTH_DATA-1:0]       rs_y;
   logic                        rs_sat;
   logic                        out_load;

   // Handshake, product resolve and next-sum arithmetic.
   always_comb begin
      advance  = !out_valid || out_ready;
      // Carry column i weighs 2^(i+1); wrap modulo 2^PW like the adder would.
      p_in     = in_sum + (in_cout << 1);
      p_ext    = {{(ACC_WIDTH - PW){s1_p[PW-1]}}, s1_p};
      // First tap of a sample starts fresh instead of adding to stale acc.
      acc_sum  = ((tap_cnt == '0) ? '0 : acc) + p_ext;
      // Tap index the incoming pair will have once S1 has drained into S2.
      if (s1_v)
         tap_after = s1_last ? '0 : tap_cnt + 1'b1;
      else
         tap_after = tap_cnt;
      out_load = advance && s1_v && s1_last && !clr;
      in_ready = advance;
      busy     = (tap_cnt != '0) || s1_v;
   end

   // S1: registered product with its valid and end-of-sample flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         s1_p    <= '0;
      end else if (clr) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
      end else if (advance) begin
         s1_v    <= in_valid;
         s1_last <= (tap_after == LAST_TAP);
         if (in_valid)
            s1_p <= p_in;
      end
   end

   // S2: accumulator and tap counter; the last tap wraps the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         tap_cnt <= '0;
      end else if (clr) begin
         acc     <= '0;
         tap_cnt <= '0;
      end else if (advance && s1_v) begin
         acc     <= acc_sum;
         tap_cnt <= s1_last ? '0 : tap_cnt + 1'b1;
      end
   end

   conv1d_round_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .WIDTH_DATA (WIDTH_DATA),
      .SHIFT      (SHIFT)
   ) u_round_sat (
      .x   (acc_sum),
      .y   (rs_y),
      .sat (rs_sat)
   );

   // OUT: result register; a load only happens while advance is high, so
   // an unconsumed result is never overwritten. clr leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (out_load) begin
         out_valid <= 1'b1;
         out_data  <= rs_y;
         out_sat   <= rs_sat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv1d_mac_acc.sv
// Bench for conv1d_mac_acc: directed literal cases plus a randomized run
// scored against a sum-of-products reference model.
module tb_conv1d_mac_acc;

   localparam int W  = 16;
   localparam int K  = 3;
   localparam int AW = 40;
   localparam int SH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_cout;
   logic [31:0]   in_sum;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic          out_sat;
   logic          busy;

   // Second instance: single-tap kernel, no fractional shift.
   logic          u1_in_valid;
   logic          u1_in_ready;
   logic [31:0]   u1_cout;
   logic [31:0]   u1_sum;
   logic          u1_out_valid;
   logic [15:0]   u1_out_data;
   logic          u1_out_sat;
   logic          u1_busy;

   int checks = 0;
   int errors = 0;
   int nout   = 0;

   always #5 clk = ~clk;

   conv1d_mac_acc #(.WIDTH_DATA(W), .KERNEL_LEN(K), .ACC_WIDTH(AW), .SHIFT(SH)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_cout(in_cout), .in_sum(in_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .busy(busy)
   );

   conv1d_mac_acc #(.WIDTH_DATA(W), .KERNEL_LEN(1), .ACC_WIDTH(AW), .SHIFT(0)) dut_k1 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0),
      .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_cout(u1_cout), .in_sum(u1_sum),
      .out_valid(u1_out_valid), .out_ready(1'b1), .out_data(u1_out_data),
      .out_sat(u1_out_sat), .busy(u1_busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Signed product the compressor pair represents.
   function automatic longint prod(input logic [31:0] s, input logic [31:0] c);
      logic [31:0] t;
      t = s + (c << 1);
      return longint'($signed(t));
   endfunction

   // {sat, data} for a full-precision total.
   function automatic logic [16:0] rsat(input longint x, input int sh);
      longint r;
      r = (x + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0))) >>> sh;
      if (r > 32767)  return {1'b1, 16'h7FFF};
      if (r < -32768) return {1'b1, 16'h8000};
      return {1'b0, r[15:0]};
   endfunction

   // Reference model state: products of the sample in progress, and
   // expected results in output order.
   longint      taps[$];
   logic [16:0] expq[$];
   logic        prev_hold;
   logic [15:0] prev_data;

   // Single compare process: runs on the falling edge, when inputs and
   // outputs are stable ahead of the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         taps.delete();
         expq.delete();
         prev_hold = 1'b0;
      end else begin
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
         if (prev_hold) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {48'd0, out_data}, {48'd0, prev_data});
         end
         if (out_valid && out_ready) begin
            nout++;
            if (expq.size() == 0) begin
               chk("unexpected_out", {47'd0, out_sat, out_data}, 64'h1_DEAD);
            end else begin
               logic [16:0] e;
               e = expq.pop_front();
               chk("out_data", {48'd0, out_data}, {48'd0, e[15:0]});
               chk("out_sat", {63'd0, out_sat}, {63'd0, e[16]});
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         if (clr) begin
            taps.delete();
         end else if (in_valid && in_ready) begin
            taps.push_back(prod(in_sum, in_cout));
            if (taps.size() == K) begin
               longint tot;
               tot = 0;
               foreach (taps[i]) tot += taps[i];
               expq.push_back(rsat(tot, SH));
               taps.delete();
            end
         end
      end
   end

   // Present one pair and hold it until accepted (bounded).
   task automatic send(input logic [31:0] s, input logic [31:0] c);
      logic ok;
      int   n;
      in_valid = 1'b1; in_sum = s; in_cout = c;
      n = 0;
      do begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   // Three back-to-back taps with out_ready=1; result must appear two
   // edges after the third accept.
   task automatic sample3(input string nm, input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [15:0] ed, input logic es);
      out_ready = 1'b1;
      send(s0, 32'd0);
      send(s1, 32'd0);
      send(s2, 32'd0);
      chk({nm, "_early"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({nm, "_data"}, {48'd0, out_data}, {48'd0, ed});
      chk({nm, "_sat"}, {63'd0, out_sat}, {63'd0, es});
   endtask

   task automatic k1_case(input string nm, input logic [31:0] s, input logic [31:0] c,
                          input logic [15:0] ed, input logic es);
      chk({nm, "_ready"}, {63'd0, u1_in_ready}, 64'd1);
      u1_in_valid = 1'b1; u1_sum = s; u1_cout = c;
      @(posedge clk); #1;
      u1_in_valid = 1'b0;
      chk({nm, "_busy"}, {63'd0, u1_busy}, 64'd1);
      @(posedge clk); #1;
      chk({nm, "_valid"}, {63'd0, u1_out_valid}, 64'd1);
      chk({nm, "_data"}, {48'd0, u1_out_data}, {48'd0, ed});
      chk({nm, "_sat"}, {63'd0, u1_out_sat}, {63'd0, es});
   endtask

   function automatic logic [31:0] rand_prod_sum(input logic [31:0] c);
      int p;
      if ($urandom_range(0, 3) == 0) return $urandom;
      p = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
      return 32'(p) - (c << 1);
   endfunction

   initial begin
      int cyc;
      int target;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = '0;
      out_ready = 1'b1;
      u1_in_valid = 1'b0; u1_sum = '0; u1_cout = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {48'd0, out_data}, 64'd0);
      chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      #1 rst_n = 1'b1;

      // Pin the reference model against hand-computed totals.
      chk("model_acc", {47'd0, rsat(256 + 512 + 768, SH)}, {47'd0, 17'h0_0006});
      chk("model_neg", {47'd0, rsat(-1152, SH)}, {47'd0, 17'h0_FFFC});
      chk("model_pos", {47'd0, rsat(1152, SH)}, {47'd0, 17'h0_0005});
      chk("model_satp", {47'd0, rsat(3 * prod(32'h4000_0000, 0), SH)}, {47'd0, 17'h1_7FFF});
      chk("model_satn", {47'd0, rsat(3 * prod(32'h8000_0000, 0), SH)}, {47'd0, 17'h1_8000});
      chk("model_prod", 64'(prod(32'h1, 32'h1)), 64'd3);

      @(posedge clk); #1;
      // Single-tap instance: carry weighting and clipping edges.
      k1_case("k1_weight", 32'h0000_0001, 32'h0000_0001, 16'd3, 1'b0);
      k1_case("k1_maxok", 32'h0000_7FFD, 32'h0000_0001, 16'h7FFF, 1'b0);
      k1_case("k1_satp", 32'h0000_8000, 32'h0, 16'h7FFF, 1'b1);
      k1_case("k1_minok", 32'hFFFF_8000, 32'h0, 16'h8000, 1'b0);
      k1_case("k1_satn", 32'hFFFF_7FFF, 32'h0, 16'h8000, 1'b1);

      // Directed three-tap samples.
      sample3("acc", 32'h100, 32'h200, 32'h300, 16'd6, 1'b0);
      sample3("neg", 32'hFFFF_FE80, 32'hFFFF_FE80, 32'hFFFF_FE80, 16'hFFFC, 1'b0);
      sample3("pos", 32'h180, 32'h180, 32'h180, 16'd5, 1'b0);
      sample3("satp", 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 16'h7FFF, 1'b1);
      sample3("satn", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 16'h8000, 1'b1);

      // Reset mid-sample after two taps.
      repeat (3) @(posedge clk);
      #1;
      send(32'h1234, 32'h0);
      send(32'h5678, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_out_data", {48'd0, out_data}, 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      sample3("after_rst", 32'h180, 32'h180, 32'h180, 16'd5, 1'b0);

      // clr after the first tap; a pair presented with clr is dropped.
      send(32'h0001_0000, 32'h0);
      clr = 1'b1; in_valid = 1'b1; in_sum = 32'h0FFF_0000; in_cout = 32'h0;
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_busy", {63'd0, busy}, 64'd0);
      sample3("after_clr", 32'hFFFF_FE80, 32'hFFFF_FE80, 32'hFFFF_FE80, 16'hFFFC, 1'b0);

      // Randomized traffic with random backpressure and one long stall.
      target = nout + 100;
      cyc = 0;
      while (nout < target && cyc < 5000) begin
         if (cyc == 40) begin
            in_valid = 1'b1;
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
               in_cout = $urandom;
               in_sum  = rand_prod_sum(in_cout);
               @(negedge clk);
               if (out_valid) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
               @(posedge clk); #1;
            end
         end
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         in_cout   = $urandom;
         in_sum    = rand_prod_sum(in_cout);
         @(posedge clk); #1;
         cyc++;
      end
      if (nout < target) chk("rand_timeout", 64'(nout), 64'(target));
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("drain_empty", 64'(expq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
